// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter.
// Port A (pipeline writeback) always wins. Port B (long-latency results) is
// queued in a small FIFO and drains whenever A is idle. A starvation counter
// and a full FIFO raise stall_req so that the pipeline inserts a bubble.
// A busy scoreboard tracks registers that have long-latency writes pending.
//
// Handshake on B: a transfer happens on a rising edge where b_valid && b_ready.
// b_ready comes from the registered FIFO count only, so a full FIFO refuses
// data even in a cycle where it also pops.
module regfile_wb_arbiter #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_dest,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_dest,
   input  logic [DATA_W-1:0] b_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_dest,
   input  logic [ADDR_W-1:0] src1,
   input  logic [ADDR_W-1:0] src2,
   output logic              hz1,
   output logic              hz2,
   output logic              stall_req,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_dest,
   output logic [DATA_W-1:0] rf_wval,
   output logic              err_reissue
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] fifo_data [DEPTH];
   logic [ADDR_W-1:0] fifo_dest [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count, count_nxt;
   logic [SW-1:0]     starve_cnt, starve_nxt;
   logic [NREG-1:0]   busy, busy_nxt;
   logic              rf_from_b;

   logic fifo_empty, fifo_full, a_req, push, pop, clr_hit, err_set, stall_nxt;

   // Arbitration, FIFO bookkeeping and starvation tracking for this cycle.
   always_comb begin
      fifo_empty = (count == '0);
      fifo_full  = (count == CW'(DEPTH));
      a_req      = a_valid && (a_dest != '0);
      push       = b_valid && !fifo_full && (b_dest != '0);
      pop        = !a_req && !fifo_empty;

      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + CW'(1);
         2'b01:   count_nxt = count - CW'(1);
         default: count_nxt = count;
      endcase

      // Only a cycle where A wins over a waiting head counts as a loss.
      starve_nxt = '0;
      if (a_req && !fifo_empty)
         starve_nxt = (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + SW'(1);

      stall_nxt = (starve_nxt >= SW'(STARVE_MAX - 1)) || (count_nxt == CW'(DEPTH));
   end

   // Busy scoreboard update: FIFO-path commits clear, issues set (set wins).
   always_comb begin
      busy_nxt = busy;
      clr_hit  = rf_we && rf_from_b;
      if (clr_hit)
         busy_nxt[rf_dest] = 1'b0;
      if (iss_en && (iss_dest != '0))
         busy_nxt[iss_dest] = 1'b1;
      // Re-issue to a register whose pending write commits this very edge is legal.
      err_set = iss_en && (iss_dest != '0) && busy[iss_dest] &&
                !(clr_hit && (rf_dest == iss_dest));
   end

   assign b_ready = !fifo_full;
   assign hz1     = (src1 != '0) && busy[src1];
   assign hz2     = (src2 != '0) && busy[src2];

   // FIFO storage; contents are don't-care while count says the slot is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= b_data;
         fifo_dest[wr_ptr] <= b_dest;
      end
   end

   // Control state and the registered write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         starve_cnt  <= '0;
         busy        <= '0;
         stall_req   <= 1'b0;
         rf_we       <= 1'b0;
         rf_dest     <= '0;
         rf_wval     <= '0;
         rf_from_b   <= 1'b0;
         err_reissue <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count       <= count_nxt;
         starve_cnt  <= starve_nxt;
         busy        <= busy_nxt;
         stall_req   <= stall_nxt;
         err_reissue <= err_reissue || err_set;
         if (a_req) begin
            rf_we     <= 1'b1;
            rf_dest   <= a_dest;
            rf_wval   <= a_data;
            rf_from_b <= 1'b0;
         end else if (pop) begin
            rf_we     <= 1'b1;
            rf_dest   <= fifo_dest[rd_ptr];
            rf_wval   <= fifo_data[rd_ptr];
            rf_from_b <= 1'b1;
         end else begin
            rf_we     <= 1'b0;
            rf_from_b <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a random phase,
// with a monitor that checks every register-file write against a model.
module tb_regfile_wb_arbiter;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int W      = ADDR_W + DATA_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              a_valid, b_valid, iss_en;
   logic [ADDR_W-1:0] a_dest, b_dest, iss_dest, src1, src2;
   logic [DATA_W-1:0] a_data, b_data;
   logic              b_ready, hz1, hz2, stall_req, rf_we, err_reissue;
   logic [ADDR_W-1:0] rf_dest;
   logic [DATA_W-1:0] rf_wval;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];
   bit                a_pend = 1'b0;
   logic [ADDR_W-1:0] a_pd;
   logic [DATA_W-1:0] a_pdata;

   regfile_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
      .iss_en(iss_en), .iss_dest(iss_dest),
      .src1(src1), .src2(src2), .hz1(hz1), .hz2(hz2),
      .stall_req(stall_req), .rf_we(rf_we), .rf_dest(rf_dest), .rf_wval(rf_wval),
      .err_reissue(err_reissue)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_valid = 0; a_dest = '0; a_data = '0;
      b_valid = 0; b_dest = '0; b_data = '0;
      iss_en = 0; iss_dest = '0; src1 = '0; src2 = '0;
   endtask

   function automatic logic [ADDR_W-1:0] rnd_reg();
      return ADDR_W'($urandom_range(1, 31));
   endfunction

   // Monitor/scoreboard: at mid-cycle, check the write produced by the last
   // edge, then record what the coming edge will accept.
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (a_pend) begin
         chk("a_we", rf_we, 1);
         chk("a_dest", rf_dest, a_pd);
         chk("a_data", rf_wval, a_pdata);
      end else if (rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("b_unexpected_we", rf_we, 0);
         end else begin
            e = exp_q.pop_front();
            chk("b_dest", rf_dest, e[W-1:DATA_W]);
            chk("b_data", rf_wval, e[DATA_W-1:0]);
         end
      end
      if (rst) begin
         exp_q.delete();
         a_pend = 1'b0;
      end else begin
         a_pend  = a_valid && (a_dest != '0);
         a_pd    = a_dest;
         a_pdata = a_data;
         if (b_valid && b_ready && (b_dest != '0))
            exp_q.push_back({b_dest, b_data});
      end
   end

   initial begin
      int stall_at;
      rst = 1'b1;
      idle();
      step();
      step();
      chk("rst_we", rf_we, 0);
      chk("rst_dest", rf_dest, 0);
      chk("rst_wval", rf_wval, 0);
      chk("rst_stall", stall_req, 0);
      chk("rst_err", err_reissue, 0);
      chk("rst_b_ready", b_ready, 1);
      rst = 1'b0;

      // A only, including the r0 no-request case.
      a_valid = 1; a_dest = 5'd3; a_data = 32'hDEAD;
      step();
      chk("aonly_we", rf_we, 1);
      chk("aonly_dest", rf_dest, 3);
      chk("aonly_wval", rf_wval, 32'hDEAD);
      a_dest = '0;
      step();
      chk("a_r0_we", rf_we, 0);
      a_valid = 0;
      step();

      // B with A idle: issue and result in the same cycle N.
      iss_en = 1; iss_dest = 5'd7; src1 = 5'd7;
      b_valid = 1; b_dest = 5'd7; b_data = 32'h55;
      step();
      iss_en = 0; b_valid = 0;
      chk("b_n1_hz1", hz1, 1);
      chk("b_n1_we", rf_we, 0);
      step();
      chk("b_n2_we", rf_we, 1);
      chk("b_n2_dest", rf_dest, 7);
      chk("b_n2_wval", rf_wval, 32'h55);
      chk("b_n2_hz1", hz1, 1);
      step();
      chk("b_n3_hz1", hz1, 0);
      chk("b_n3_we", rf_we, 0);

      // Register 0 on every input.
      iss_en = 1; iss_dest = '0; b_valid = 1; b_dest = '0; b_data = 32'h1234;
      chk("r0_b_ready", b_ready, 1);
      step();
      iss_en = 0; b_valid = 0; src1 = '0; src2 = '0;
      chk("r0_hz1", hz1, 0);
      chk("r0_hz2", hz2, 0);
      step();
      chk("r0_no_we", rf_we, 0);

      // Contention: one B entry against a saturating A.
      a_valid = 1; a_dest = rnd_reg(); a_data = $urandom;
      b_valid = 1; b_dest = 5'd9; b_data = 32'hB0B0_0009;
      step();
      b_valid = 0;
      stall_at = 0;
      for (int i = 1; i <= 20 && stall_at == 0; i++) begin
         if (stall_req) stall_at = i;
         else begin
            a_dest = rnd_reg(); a_data = $urandom;
            step();
         end
      end
      chk("starve_stall_cycle", stall_at, 8);
      a_valid = 0;
      step();
      chk("starve_head_dest", rf_dest, 9);
      chk("starve_stall_clear", stall_req, 0);

      // Full: four pushes while A saturates, then drain.
      a_valid = 1;
      for (int k = 0; k < 4; k++) begin
         a_dest = rnd_reg(); a_data = $urandom;
         b_valid = 1; b_dest = ADDR_W'(10 + k); b_data = 32'hF000_0000 + k;
         step();
      end
      chk("full_b_ready", b_ready, 0);
      chk("full_stall", stall_req, 1);
      b_dest = 5'd20; b_data = 32'hF000_0020;
      a_valid = 0;
      step();
      chk("full_pop_ready", b_ready, 1);
      step();
      b_valid = 0;
      for (int k = 0; k < 6; k++) step();
      chk("drain_b_ready", b_ready, 1);
      chk("drain_stall", stall_req, 0);

      // Same-cycle commit and re-issue of r5.
      iss_en = 1; iss_dest = 5'd5; src1 = 5'd5;
      step();
      iss_en = 0;
      b_valid = 1; b_dest = 5'd5; b_data = 32'h5555;
      step();
      b_valid = 0;
      step();
      chk("same_commit_dest", rf_dest, 5);
      chk("same_pre_hz1", hz1, 1);
      iss_en = 1; iss_dest = 5'd5;
      step();
      iss_en = 0;
      chk("same_busy5", hz1, 1);
      chk("same_err", err_reissue, 0);
      iss_en = 1;
      step();
      iss_en = 0;
      chk("reissue_err", err_reissue, 1);

      // Reset with three queued entries.
      a_valid = 1;
      for (int k = 0; k < 3; k++) begin
         a_dest = rnd_reg(); a_data = $urandom;
         b_valid = 1; b_dest = ADDR_W'(11 + k); b_data = 32'hC000_0000 + k;
         step();
      end
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("post_rst_we", rf_we, 0);
         step();
      end
      chk("post_rst_b_ready", b_ready, 1);
      chk("post_rst_err", err_reissue, 0);
      for (int r = 0; r < 32; r++) begin
         src1 = ADDR_W'(r);
         #1;
         chk("post_rst_busy", hz1, 0);
      end

      // Random traffic; the pipeline honours stall_req.
      for (int c = 0; c < 300; c++) begin
         a_valid = stall_req ? 1'b0 : ($urandom_range(0, 3) != 0);
         a_dest  = ADDR_W'($urandom_range(0, 31));
         a_data  = $urandom;
         b_valid = ($urandom_range(0, 1) == 1);
         b_dest  = ADDR_W'($urandom_range(0, 31));
         b_data  = $urandom;
         src1    = ADDR_W'($urandom_range(0, 31));
         src2    = ADDR_W'($urandom_range(0, 31));
         step();
      end
      idle();
      for (int k = 0; k < 8; k++) step();
      chk("rand_all_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
